// File: rtl/tlu_dut_rx.sv
`default_nettype none
// ============================================================================
// Module   : tlu_dut_rx
// Purpose  : DUT-side TLU trigger/handshake receiver. Accepts TLU_TRIGGER,
//            acknowledges with TLU_BUSY, clocks in the LSB-first trigger ID
//            with TLU_CLOCK and holds busy while local readout is active.
// Revision : 1.0 - initial release
// ============================================================================
module tlu_dut_rx #(
    parameter int ID_BITS      = 15,
    parameter int CLK_DIV      = 8,
    parameter int MIN_TRIG_LEN = 2,
    parameter int ACK_TIMEOUT  = 255
) (
    input  logic               SYS_CLK,
    input  logic               SYS_RST_N,
    input  logic               ENABLE,
    input  logic               DUT_BUSY,
    input  logic               TLU_TRIGGER,
    input  logic               TLU_RESET,
    output logic               TLU_CLOCK,
    output logic               TLU_BUSY,
    output logic               TRIG_OUT,
    output logic [ID_BITS-1:0] TRIG_ID,
    output logic               ID_VALID,
    output logic [31:0]        TRIG_CNT,
    output logic [7:0]         ERR_CNT,
    output logic               TIMEOUT_ERR
);

    localparam int DEB_W = (MIN_TRIG_LEN < 2) ? 1 : $clog2(MIN_TRIG_LEN);
    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
    localparam int PER_W = $clog2(2 * CLK_DIV);
    localparam int BIT_W = (ID_BITS < 2) ? 1 : $clog2(ID_BITS);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(MIN_TRIG_LEN - 1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(2 * CLK_DIV - 1);
    localparam logic [PER_W-1:0] CLK_HI   = PER_W'(CLK_DIV);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(ID_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACK     = 3'd1,
        S_CLOCK   = 3'd2,
        S_HOLD    = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               trig_meta;
    logic               trig_s;
    logic               rst_meta;
    logic               rst_s;
    logic [DEB_W-1:0]   deb_cnt;
    logic [ACK_W-1:0]   ack_cnt;
    logic [PER_W-1:0]   per_cnt;
    logic [PER_W-1:0]   per_next;
    logic [BIT_W-1:0]   bit_idx;
    logic [BIT_W-1:0]   bit_next;
    logic [ID_BITS-2:0] shreg;
    logic [ID_BITS-1:0] shifted;
    logic               accept;
    logic               timeout;
    logic               sample;
    logic               last_bit;

    // Shift right: the new bit enters at the MSB so bit 0 ends at the LSB.
    assign shifted = {trig_s, shreg};

    // Two-flop synchronisers for the asynchronous link inputs.
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            trig_meta <= 1'b0;
            trig_s    <= 1'b0;
            rst_meta  <= 1'b0;
            rst_s     <= 1'b0;
        end else begin
            trig_meta <= TLU_TRIGGER;
            trig_s    <= trig_meta;
            rst_meta  <= TLU_RESET;
            rst_s     <= rst_meta;
        end
    end

    // State register.
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the single-cycle events that drive the datapath.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        timeout    = 1'b0;
        sample     = 1'b0;
        last_bit   = 1'b0;
        per_next   = '0;
        bit_next   = '0;
        case (state)
            S_IDLE: begin
                if (trig_s && ENABLE && (deb_cnt == DEB_LAST)) begin
                    accept     = 1'b1;
                    state_next = S_ACK;
                end
            end
            S_ACK: begin
                if (!trig_s) begin
                    state_next = S_CLOCK;
                end else if (ack_cnt == ACK_LAST) begin
                    timeout    = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_CLOCK: begin
                bit_next = bit_idx;
                per_next = per_cnt + 1'b1;
                if (per_cnt == PER_LAST) begin
                    sample   = 1'b1;
                    per_next = '0;
                    bit_next = bit_idx + 1'b1;
                    if (bit_idx == BIT_LAST) begin
                        last_bit   = 1'b1;
                        state_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!DUT_BUSY) begin
                    state_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!trig_s) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Counters, ID shift register and registered outputs.
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            deb_cnt     <= '0;
            ack_cnt     <= '0;
            per_cnt     <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            TRIG_ID     <= '0;
            ID_VALID    <= 1'b0;
            TRIG_OUT    <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
            TLU_BUSY    <= 1'b0;
            TLU_CLOCK   <= 1'b0;
            TRIG_CNT    <= '0;
            ERR_CNT     <= '0;
        end else begin
            // Debounce only counts a continuous, enabled high in IDLE.
            if ((state == S_IDLE) && trig_s && ENABLE && !accept) begin
                deb_cnt <= deb_cnt + 1'b1;
            end else begin
                deb_cnt <= '0;
            end

            ack_cnt <= (state == S_ACK) ? ack_cnt + 1'b1 : '0;
            per_cnt <= per_next;
            bit_idx <= bit_next;

            if (sample) begin
                shreg <= shifted[ID_BITS-1:1];
            end
            if (last_bit) begin
                TRIG_ID <= shifted;
            end

            ID_VALID    <= last_bit;
            TRIG_OUT    <= accept;
            TIMEOUT_ERR <= timeout;
            // Busy follows the current state, so it rises one cycle after
            // TRIG_OUT and falls one cycle after HOLD is left.
            TLU_BUSY    <= (state == S_ACK) || (state == S_CLOCK) || (state == S_HOLD);
            TLU_CLOCK   <= (state_next == S_CLOCK) && (per_next < CLK_HI);

            // A synchronised TLU_RESET wins over a same-cycle acceptance.
            if (rst_s) begin
                TRIG_CNT <= '0;
            end else if (accept) begin
                TRIG_CNT <= TRIG_CNT + 32'd1;
            end

            if (timeout && (ERR_CNT != 8'hFF)) begin
                ERR_CNT <= ERR_CNT + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tlu_dut_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlu_dut_rx
// Purpose  : Self-checking bench for tlu_dut_rx: a TLU master model drives
//            random and directed trigger IDs; a scoreboard of expected IDs,
//            trigger and error counts is compared against the outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlu_dut_rx;

    logic        SYS_CLK = 1'b0;
    logic        SYS_RST_N;
    logic        ENABLE;
    logic        DUT_BUSY;
    logic        TLU_TRIGGER;
    logic        TLU_RESET;
    logic        TLU_CLOCK;
    logic        TLU_BUSY;
    logic        TRIG_OUT;
    logic [14:0] TRIG_ID;
    logic        ID_VALID;
    logic [31:0] TRIG_CNT;
    logic [7:0]  ERR_CNT;
    logic        TIMEOUT_ERR;

    int n_cmp  = 0;
    int n_fail = 0;

    // Event counters gathered by the output monitor.
    int n_rise = 0, n_badw = 0, n_trig = 0, n_idv = 0, n_to = 0;
    int n_busy = 0, n_wide = 0, run = 0;
    logic prev_clk = 1'b0, prev_to = 1'b0, prev_iv = 1'b0, seen_fall = 1'b0;

    tlu_dut_rx #(
        .ID_BITS      (15),
        .CLK_DIV      (8),
        .MIN_TRIG_LEN (2),
        .ACK_TIMEOUT  (255)
    ) dut (
        .SYS_CLK     (SYS_CLK),
        .SYS_RST_N   (SYS_RST_N),
        .ENABLE      (ENABLE),
        .DUT_BUSY    (DUT_BUSY),
        .TLU_TRIGGER (TLU_TRIGGER),
        .TLU_RESET   (TLU_RESET),
        .TLU_CLOCK   (TLU_CLOCK),
        .TLU_BUSY    (TLU_BUSY),
        .TRIG_OUT    (TRIG_OUT),
        .TRIG_ID     (TRIG_ID),
        .ID_VALID    (ID_VALID),
        .TRIG_CNT    (TRIG_CNT),
        .ERR_CNT     (ERR_CNT),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    // 10 ns system clock.
    always #5 SYS_CLK = ~SYS_CLK;

    // Output monitor sampled on the falling edge: TLU_CLOCK run lengths,
    // pulse counts and single-cycle pulse widths.
    always @(negedge SYS_CLK) begin
        if (!SYS_RST_N) begin
            prev_clk  <= 1'b0;
            run       <= 0;
            seen_fall <= 1'b0;
        end else begin
            if (TLU_CLOCK != prev_clk) begin
                if (prev_clk && run != 8) n_badw <= n_badw + 1;
                if (!prev_clk && seen_fall && run < 8) n_badw <= n_badw + 1;
                if (TLU_CLOCK) n_rise <= n_rise + 1;
                else seen_fall <= 1'b1;
                run <= 1;
            end else begin
                run <= run + 1;
            end
            prev_clk <= TLU_CLOCK;
        end
        if (TRIG_OUT) n_trig <= n_trig + 1;
        if (ID_VALID) n_idv <= n_idv + 1;
        if (TIMEOUT_ERR) n_to <= n_to + 1;
        if (TLU_BUSY) n_busy <= n_busy + 1;
        if ((TRIG_OUT && prev_to) || (ID_VALID && prev_iv)) n_wide <= n_wide + 1;
        prev_to <= TRIG_OUT;
        prev_iv <= ID_VALID;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // TLU master: raise trigger, wait for busy, drop it, then present one
    // ID bit after each TLU_CLOCK rise. abort_period >= 0 pulls the
    // asynchronous reset in the low half of that period and returns.
    task automatic handshake(input logic [14:0] id, input int abort_period,
                             output bit ok, output int lat_trig, output int lat_busy);
        int n;
        ok = 1'b1;
        TLU_TRIGGER = 1'b1;
        n = 0;
        do begin @(negedge SYS_CLK); n++; end while (!TRIG_OUT && n < 50);
        lat_trig = n;
        n = 0;
        do begin @(negedge SYS_CLK); n++; end while (!TLU_BUSY && n < 10);
        lat_busy = n;
        if (!TLU_BUSY) begin ok = 1'b0; return; end
        TLU_TRIGGER = 1'b0;
        for (int k = 0; k < 15; k++) begin
            n = 0;
            while (!TLU_CLOCK && n < 100) begin @(negedge SYS_CLK); n++; end
            if (!TLU_CLOCK) begin ok = 1'b0; return; end
            TLU_TRIGGER = id[k];
            if (k == abort_period) begin
                repeat (10) @(negedge SYS_CLK);
                #2 SYS_RST_N = 1'b0;
                TLU_TRIGGER = 1'b0;
                return;
            end
            n = 0;
            while (TLU_CLOCK && n < 100) begin @(negedge SYS_CLK); n++; end
        end
        n = 0;
        while (!ID_VALID && n < 50) begin @(negedge SYS_CLK); n++; end
        if (!ID_VALID) ok = 1'b0;
        TLU_TRIGGER = 1'b0;
    endtask

    task automatic wait_busy_low(output int n);
        n = 0;
        do begin @(negedge SYS_CLK); n++; end while (TLU_BUSY && n < 20);
    endtask

    initial begin
        logic [14:0] ids [3] = '{15'h0000, 15'h7FFF, 15'h0001};
        logic [14:0] id;
        logic [14:0] exp_id  = '0;
        int          exp_cnt = 0;
        int          exp_err = 0;
        int          r0, t0, v0, b0, to0, lt, lb, n;
        bit          ok;

        SYS_RST_N = 1'b0; ENABLE = 1'b1; DUT_BUSY = 1'b0;
        TLU_TRIGGER = 1'b0; TLU_RESET = 1'b0;
        repeat (3) @(negedge SYS_CLK);
        check("rst_busy",    TLU_BUSY,    0);
        check("rst_clock",   TLU_CLOCK,   0);
        check("rst_trigout", TRIG_OUT,    0);
        check("rst_id",      TRIG_ID,     0);
        check("rst_idvalid", ID_VALID,    0);
        check("rst_cnt",     TRIG_CNT,    0);
        check("rst_err",     ERR_CNT,     0);
        check("rst_timeout", TIMEOUT_ERR, 0);
        SYS_RST_N = 1'b1;
        repeat (3) @(negedge SYS_CLK);

        // First ID with latency and TLU_CLOCK shape checks.
        r0 = n_rise; t0 = n_trig; v0 = n_idv;
        id = 15'h5A3C;
        handshake(id, -1, ok, lt, lb);
        exp_id = id; exp_cnt++;
        check("hs1_ok", ok, 1);
        check("hs1_trig_latency", lt, 4);
        check("hs1_busy_after_trigout", lb, 1);
        check("hs1_id", TRIG_ID, exp_id);
        wait_busy_low(n);
        check("hs1_busy_fall", n, 2);
        repeat (20) @(negedge SYS_CLK);
        check("hs1_clock_pulses", n_rise - r0, 15);
        check("hs1_trigout_pulses", n_trig - t0, 1);
        check("hs1_idvalid_pulses", n_idv - v0, 1);
        check("hs1_cnt", TRIG_CNT, exp_cnt);
        check("hs1_clock_shape", n_badw, 0);

        // Directed extremes followed by random IDs, back to back.
        for (int i = 0; i < 7; i++) begin
            id = (i < 3) ? ids[i] : 15'($urandom);
            r0 = n_rise;
            handshake(id, -1, ok, lt, lb);
            exp_id = id & 15'h7FFF; exp_cnt++;
            check("b2b_ok", ok, 1);
            check("b2b_id", TRIG_ID, exp_id);
            wait_busy_low(n);
            repeat (2) @(negedge SYS_CLK);
            check("b2b_clock_pulses", n_rise - r0, 15);
        end
        check("b2b_cnt", TRIG_CNT, exp_cnt);

        // One-cycle glitch must not be accepted.
        t0 = n_trig; b0 = n_busy;
        TLU_TRIGGER = 1'b1;
        @(negedge SYS_CLK);
        TLU_TRIGGER = 1'b0;
        repeat (20) @(negedge SYS_CLK);
        check("glitch_trigout", n_trig - t0, 0);
        check("glitch_busy", n_busy - b0, 0);
        check("glitch_cnt", TRIG_CNT, exp_cnt);

        // Disabled receiver ignores a long trigger.
        ENABLE = 1'b0;
        TLU_TRIGGER = 1'b1;
        repeat (20) @(negedge SYS_CLK);
        TLU_TRIGGER = 1'b0;
        repeat (5) @(negedge SYS_CLK);
        check("disabled_trigout", n_trig - t0, 0);
        check("disabled_cnt", TRIG_CNT, exp_cnt);
        ENABLE = 1'b1;

        // Local readout keeps busy asserted for 1000 cycles.
        DUT_BUSY = 1'b1;
        id = 15'($urandom);
        handshake(id, -1, ok, lt, lb);
        exp_id = id; exp_cnt++;
        check("dutbusy_ok", ok, 1);
        check("dutbusy_id", TRIG_ID, exp_id);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge SYS_CLK);
            if (!TLU_BUSY) n++;
        end
        check("dutbusy_busy_low_cycles", n, 0);
        DUT_BUSY = 1'b0;
        wait_busy_low(n);
        check("dutbusy_busy_fall", n, 2);

        // Synchronised TLU_RESET clears the trigger counter.
        TLU_RESET = 1'b1;
        @(negedge SYS_CLK);
        TLU_RESET = 1'b0;
        repeat (5) @(negedge SYS_CLK);
        exp_cnt = 0;
        check("tlureset_cnt", TRIG_CNT, exp_cnt);

        // Stuck-high trigger: timeout every round, error count saturates.
        to0 = n_to;
        for (int i = 0; i < 257; i++) begin
            TLU_TRIGGER = 1'b1;
            n = 0;
            do begin @(negedge SYS_CLK); n++; end while (!TRIG_OUT && n < 20);
            n = 0;
            do begin @(negedge SYS_CLK); n++; end while (!TIMEOUT_ERR && n < 400);
            exp_cnt++;
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
            if (i == 0) begin
                check("timeout_latency", n, 255);
                t0 = n_trig;
                wait_busy_low(n);
                check("timeout_busy_released", TLU_BUSY, 0);
                repeat (30) @(negedge SYS_CLK);
                check("timeout_no_retrigger", n_trig - t0, 0);
                check("timeout_busy_stays_low", TLU_BUSY, 0);
                check("timeout_err1", ERR_CNT, exp_err);
                check("timeout_id_kept", TRIG_ID, exp_id);
            end else if (!TIMEOUT_ERR) begin
                check("timeout_round_seen", 0, 1);
                break;
            end
            TLU_TRIGGER = 1'b0;
            repeat (6) @(negedge SYS_CLK);
        end
        check("timeout_pulses", n_to - to0, 257);
        check("timeout_err_saturated", ERR_CNT, exp_err);
        check("timeout_cnt", TRIG_CNT, exp_cnt);

        // Asynchronous reset during the 7th TLU_CLOCK period.
        handshake(15'($urandom), 6, ok, lt, lb);
        #1;
        check("abort_busy", TLU_BUSY, 0);
        check("abort_clock", TLU_CLOCK, 0);
        check("abort_id", TRIG_ID, 0);
        check("abort_cnt", TRIG_CNT, 0);
        repeat (2) @(negedge SYS_CLK);
        SYS_RST_N = 1'b1;
        exp_cnt = 0; exp_err = 0; exp_id = '0;
        repeat (3) @(negedge SYS_CLK);
        r0 = n_rise;
        id = 15'($urandom);
        handshake(id, -1, ok, lt, lb);
        exp_id = id; exp_cnt++;
        check("post_abort_ok", ok, 1);
        check("post_abort_id", TRIG_ID, exp_id);
        wait_busy_low(n);
        repeat (3) @(negedge SYS_CLK);
        check("post_abort_pulses", n_rise - r0, 15);
        check("post_abort_cnt", TRIG_CNT, exp_cnt);
        check("post_abort_err", ERR_CNT, exp_err);

        check("clock_shape_overall", n_badw, 0);
        check("single_cycle_pulses", n_wide, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
